ifu_imem_rsp: RTL and testbench

IFU_IMEM_RSP -- requirements
Module: ifu_imem_rsp

---
 rtl/ifu_imem_rsp_if.sv | 42 ++++
 rtl/ifu_imem_rsp.sv | 180 ++++++++++++++++++
 tb/tb_ifu_imem_rsp.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_imem_rsp_if.sv
// ----------------------------------------------------------------------------
// ifu_imem_rsp_if
// Bundles the fetch request/response channels and the synchronous SRAM read
// port used by ifu_imem_rsp.
//   master : fetch unit + SRAM side (drives requests, response ready, rdata)
//   slave  : ifu_imem_rsp (drives req ready, response, SRAM cs/addr)
// With IFU_IMEM_RSP_ERR_EN defined the bundle also carries ifu_rsp_err.
// ----------------------------------------------------------------------------
interface ifu_imem_rsp_if #(
    parameter int PC_W = 32,
    parameter int IW   = 32,
    parameter int AW   = 12
) ();
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [PC_W-1:0] ifu_req_pc;
    logic            ifu_rsp_valid;
    logic            ifu_rsp_ready;
    logic [IW-1:0]   ifu_rsp_instr;
`ifdef IFU_IMEM_RSP_ERR_EN
    logic            ifu_rsp_err;
`endif
    logic            sram_cs;
    logic [AW-1:0]   sram_addr;
    logic [IW-1:0]   sram_rdata;

    modport master (
        output ifu_req_valid, ifu_req_pc, ifu_rsp_ready, sram_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, sram_cs, sram_addr
`ifdef IFU_IMEM_RSP_ERR_EN
        , input ifu_rsp_err
`endif
    );

    modport slave (
        input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready, sram_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, sram_cs, sram_addr
`ifdef IFU_IMEM_RSP_ERR_EN
        , output ifu_rsp_err
`endif
    );
endinterface

// File: rtl/ifu_imem_rsp.sv
// ----------------------------------------------------------------------------
// ifu_imem_rsp
// Instruction-fetch responder: accepts fetch addresses, reads one word from a
// synchronous SRAM per request (with WAIT_CYC optional wait states) and
// returns responses strictly in request order. A one-entry pending buffer lets
// a new request be accepted while a response is waiting for ifu_rsp_ready.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ifu_imem_rsp_if.slave: request channel (valid/ready/pc), response
//          channel (valid/ready/instr), SRAM read port (cs/addr/rdata)
// Optional feature macro IFU_IMEM_RSP_ERR_EN: adds ifu_rsp_err; misaligned or
// out-of-window addresses skip the SRAM and return instr=0 with err=1.
// ----------------------------------------------------------------------------
module ifu_imem_rsp #(
    parameter int              PC_W     = 32,
    parameter int              IW       = 32,
    parameter int              AW       = 12,
    parameter int              WAIT_CYC = 0,
    parameter logic [PC_W-1:0] BASE     = 32'h8000_0000
) (
    input logic           clk,
    input logic           rst,
    ifu_imem_rsp_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t          state_r, state_nxt_s;
    logic [3:0]      cnt_r, cnt_nxt_s;
    logic [PC_W-1:0] cur_pc_r, cur_pc_nxt_s;
    logic            pend_vld_r, pend_vld_nxt_s;
    logic [PC_W-1:0] pend_pc_r, pend_pc_nxt_s;
    logic            start_s;
    logic [PC_W-1:0] start_pc_s;
    logic            capture_s;
    logic            req_ready_r, rsp_valid_r, sram_cs_r;
    logic [AW-1:0]   sram_addr_r;
    logic [IW-1:0]   rsp_instr_r;
    logic            req_hs_s, rsp_hs_s;
    logic            cs_nxt_s;
    logic            acc_err_s;

`ifdef IFU_IMEM_RSP_ERR_EN
    logic            rsp_err_r;

    // Address outside the SRAM window or not word aligned.
    function automatic logic addr_err(input logic [PC_W-1:0] pc);
        addr_err = (pc[1:0] != 2'b00) || (pc[PC_W-1:AW+2] != BASE[PC_W-1:AW+2]);
    endfunction

    assign acc_err_s = addr_err(cur_pc_r);
    assign cs_nxt_s  = (state_nxt_s == RD) && !addr_err(cur_pc_nxt_s);
    assign bus.ifu_rsp_err = rsp_err_r;
`else
    // Without the error feature, pc[1:0], the upper address bits and BASE
    // are intentionally ignored (the index simply wraps).
    logic unused_pc_s;
    assign unused_pc_s = ^{cur_pc_r[PC_W-1:AW+2], cur_pc_r[1:0], BASE};
    assign acc_err_s   = 1'b0;
    assign cs_nxt_s    = (state_nxt_s == RD);
`endif

    // Handshakes are qualified by registered ready/valid, so ready never
    // depends combinationally on ifu_req_valid or ifu_rsp_ready.
    assign req_hs_s = bus.ifu_req_valid && req_ready_r;
    assign rsp_hs_s = rsp_valid_r && bus.ifu_rsp_ready;

    assign bus.ifu_req_ready = req_ready_r;
    assign bus.ifu_rsp_valid = rsp_valid_r;
    assign bus.ifu_rsp_instr = rsp_instr_r;
    assign bus.sram_cs       = sram_cs_r;
    assign bus.sram_addr     = sram_addr_r;

    // Next-state logic: sequencing of accesses and the pending buffer.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        cur_pc_nxt_s   = cur_pc_r;
        pend_vld_nxt_s = pend_vld_r;
        pend_pc_nxt_s  = pend_pc_r;
        start_s        = 1'b0;
        start_pc_s     = cur_pc_r;
        capture_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_hs_s) begin
                    start_s    = 1'b1;
                    start_pc_s = bus.ifu_req_pc;
                end else begin
                    start_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RD;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RD: begin
                state_nxt_s = RSP;
                capture_s   = 1'b1;
            end
            RSP: begin
                if (rsp_hs_s) begin
                    // Pending request is older than anything arriving now.
                    if (pend_vld_r) begin
                        start_s        = 1'b1;
                        start_pc_s     = pend_pc_r;
                        pend_vld_nxt_s = 1'b0;
                    end else if (req_hs_s) begin
                        start_s    = 1'b1;
                        start_pc_s = bus.ifu_req_pc;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (req_hs_s) begin
                    pend_vld_nxt_s = 1'b1;
                    pend_pc_nxt_s  = bus.ifu_req_pc;
                end else begin
                    pend_vld_nxt_s = pend_vld_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (start_s) begin
            state_nxt_s  = (WAIT_CYC > 0) ? WAIT : RD;
            cnt_nxt_s    = WAIT_LOAD;
            cur_pc_nxt_s = start_pc_s;
        end else begin
            cur_pc_nxt_s = cur_pc_r;
        end
    end

    // State, buffers and registered outputs; reset overrides any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            cur_pc_r    <= '0;
            pend_vld_r  <= 1'b0;
            pend_pc_r   <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            sram_cs_r   <= 1'b0;
            sram_addr_r <= '0;
            rsp_instr_r <= '0;
`ifdef IFU_IMEM_RSP_ERR_EN
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cur_pc_r    <= cur_pc_nxt_s;
            pend_vld_r  <= pend_vld_nxt_s;
            pend_pc_r   <= pend_pc_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE) || ((state_nxt_s == RSP) && !pend_vld_nxt_s);
            rsp_valid_r <= (state_nxt_s == RSP);
            sram_cs_r   <= cs_nxt_s;
            sram_addr_r <= cur_pc_nxt_s[AW+1:2];
            if (capture_s) begin
                rsp_instr_r <= acc_err_s ? '0 : bus.sram_rdata;
`ifdef IFU_IMEM_RSP_ERR_EN
                rsp_err_r   <= acc_err_s;
`endif
            end else begin
                rsp_instr_r <= rsp_instr_r;
            end
        end
    end
endmodule

// File: tb/tb_ifu_imem_rsp.sv
// ----------------------------------------------------------------------------
// tb_ifu_imem_rsp
// Self-checking bench for ifu_imem_rsp. dut0 (WAIT_CYC=0) runs directed and
// random traffic and is compared every cycle against a transaction-level
// model: an in-order queue of outstanding requests, each with the cycle its
// access starts. dut3 (WAIT_CYC=3) is checked for wait-state latency.
// The SRAM model presents mem[sram_addr] for the cycle sram_cs is held and
// random junk otherwise, so sampling at the wrong time is visible.
// ----------------------------------------------------------------------------
module tb_ifu_imem_rsp;
    localparam int          PC_W = 32;
    localparam int          IW   = 32;
    localparam int          AW   = 12;
    localparam int          WC0  = 0;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_imem_rsp_if #(.PC_W(PC_W), .IW(IW), .AW(AW)) bus0 ();
    ifu_imem_rsp_if #(.PC_W(PC_W), .IW(IW), .AW(AW)) bus3 ();

    ifu_imem_rsp #(.PC_W(PC_W), .IW(IW), .AW(AW), .WAIT_CYC(WC0), .BASE(BASE))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ifu_imem_rsp #(.PC_W(PC_W), .IW(IW), .AW(AW), .WAIT_CYC(3), .BASE(BASE))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [IW-1:0] mem [0:(1<<AW)-1];
    logic [IW-1:0] junk_r;
    always @(posedge clk) junk_r <= $urandom;
    assign bus0.sram_rdata = bus0.sram_cs ? mem[bus0.sram_addr] : junk_r;
    assign bus3.sram_rdata = bus3.sram_cs ? mem[bus3.sram_addr] : ~junk_r;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit pc_err(input logic [31:0] pc);
`ifdef IFU_IMEM_RSP_ERR_EN
        return (pc[1:0] != 2'b00) || (pc[31:AW+2] != BASE[31:AW+2]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [IW-1:0] exp_word(input logic [31:0] pc);
        return pc_err(pc) ? '0 : mem[pc[AW+1:2]];
    endfunction

    // ---------------- transaction-level model of dut0 ----------------
    logic [31:0] q_pc[$];
    int          q_start[$];  // -1: access not started yet (waiting behind older one)
    bit          exp_valid, exp_cs, exp_ready, req_hs, rsp_hs;

    always @(negedge clk) begin
        if (rst) begin
            q_pc.delete();
            q_start.delete();
        end else begin
            exp_valid = (q_pc.size() > 0) && (q_start[0] >= 0) && (cyc >= q_start[0] + 2 + WC0);
            exp_cs    = (q_pc.size() > 0) && (q_start[0] >= 0) && (cyc == q_start[0] + 1 + WC0)
                        && !pc_err(q_pc[0]);
            exp_ready = (q_pc.size() == 0) || ((q_pc.size() == 1) && exp_valid);
            chk("m_req_ready", 64'(bus0.ifu_req_ready), 64'(exp_ready));
            chk("m_rsp_valid", 64'(bus0.ifu_rsp_valid), 64'(exp_valid));
            chk("m_sram_cs",   64'(bus0.sram_cs),       64'(exp_cs));
            if (exp_cs) chk("m_sram_addr", 64'(bus0.sram_addr), 64'(q_pc[0][AW+1:2]));
            if (exp_valid) begin
                chk("m_rsp_instr", 64'(bus0.ifu_rsp_instr), 64'(exp_word(q_pc[0])));
`ifdef IFU_IMEM_RSP_ERR_EN
                chk("m_rsp_err", 64'(bus0.ifu_rsp_err), 64'(pc_err(q_pc[0])));
`endif
            end
            req_hs = bus0.ifu_req_valid && exp_ready;
            rsp_hs = exp_valid && bus0.ifu_rsp_ready;
            if (rsp_hs) begin
                void'(q_pc.pop_front());
                void'(q_start.pop_front());
                if (q_pc.size() > 0) q_start[0] = cyc;
            end
            if (req_hs) begin
                q_start.push_back((q_pc.size() == 0) ? cyc : -1);
                q_pc.push_back(bus0.ifu_req_pc);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [31:0] pc, input logic rr);
        bus0.ifu_req_valid = v;
        bus0.ifu_req_pc    = pc;
        bus0.ifu_rsp_ready = rr;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[1] = 32'h0000_0513;
        mem[2] = 32'h0011_0113;
        req0(1'b0, 32'h0, 1'b1);
        bus3.ifu_req_valid = 1'b0;
        bus3.ifu_req_pc    = 32'h0;
        bus3.ifu_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, first cycle after reset.
        @(negedge clk);
        chk("rst_ready0", 64'(bus0.ifu_req_ready), 64'd1);
        chk("rst_valid0", 64'(bus0.ifu_rsp_valid), 64'd0);
        chk("rst_cs0",    64'(bus0.sram_cs),       64'd0);
        chk("rst_instr0", 64'(bus0.ifu_rsp_instr), 64'd0);
        chk("rst_ready3", 64'(bus3.ifu_req_ready), 64'd1);

        // Single fetch, WAIT_CYC=0: cs at T+1, response at T+2.
        next_cyc(); req0(1'b1, 32'h8000_0004, 1'b1);
        next_cyc(); req0(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("b2_cs",   64'(bus0.sram_cs),   64'd1);
        chk("b2_addr", 64'(bus0.sram_addr), 64'd1);
        next_cyc(); @(negedge clk);
        chk("b2_valid", 64'(bus0.ifu_rsp_valid), 64'd1);
        chk("b2_instr", 64'(bus0.ifu_rsp_instr), 64'h0000_0513);
        next_cyc(); @(negedge clk);
        chk("b2_idle_valid", 64'(bus0.ifu_rsp_valid), 64'd0);

        // Response stalled 5 cycles, second request parked in pending buffer.
        next_cyc(); req0(1'b1, 32'h8000_0004, 1'b0);
        next_cyc(); req0(1'b0, 32'h0, 1'b0);
        next_cyc(); req0(1'b1, 32'h8000_0008, 1'b0);
        @(negedge clk);
        chk("pend_rdy_before", 64'(bus0.ifu_req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            next_cyc(); req0(1'b0, 32'h0, 1'b0);
            @(negedge clk);
            chk("pend_rdy_low", 64'(bus0.ifu_req_ready), 64'd0);
            chk("pend_hold",    64'(bus0.ifu_rsp_instr), 64'h0000_0513);
        end
        next_cyc(); req0(1'b0, 32'h0, 1'b1);
        next_cyc(); @(negedge clk);
        chk("pend_gap_valid", 64'(bus0.ifu_rsp_valid), 64'd0);
        next_cyc(); @(negedge clk);
        chk("pend_w2_valid", 64'(bus0.ifu_rsp_valid), 64'd1);
        chk("pend_w2_instr", 64'(bus0.ifu_rsp_instr), 64'h0011_0113);

        // Back-to-back: response and new request handshake together.
        next_cyc(); req0(1'b1, 32'h8000_0004, 1'b1);
        next_cyc(); req0(1'b0, 32'h0, 1'b1);
        next_cyc(); req0(1'b1, 32'h8000_0008, 1'b1);
        next_cyc(); req0(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("b2b_ready_rd", 64'(bus0.ifu_req_ready), 64'd0);
        chk("b2b_cs",       64'(bus0.sram_cs),       64'd1);
        next_cyc(); @(negedge clk);
        chk("b2b_valid", 64'(bus0.ifu_rsp_valid), 64'd1);
        chk("b2b_instr", 64'(bus0.ifu_rsp_instr), 64'h0011_0113);

        // Reset while in RD: the access is dropped.
        next_cyc(); req0(1'b1, 32'h8000_0004, 1'b1);
        next_cyc(); req0(1'b0, 32'h0, 1'b1); rst = 1'b1;
        next_cyc(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstrd_valid", 64'(bus0.ifu_rsp_valid), 64'd0);
            chk("rstrd_ready", 64'(bus0.ifu_req_ready), 64'd1);
            next_cyc();
        end

`ifdef IFU_IMEM_RSP_ERR_EN
        // Misaligned and out-of-window fetches: no SRAM access, err response.
        for (int j = 0; j < 2; j++) begin
            req0(1'b1, (j == 0) ? 32'h8000_0002 : 32'h0000_0000, 1'b1);
            next_cyc(); req0(1'b0, 32'h0, 1'b1);
            @(negedge clk);
            chk("err_no_cs", 64'(bus0.sram_cs), 64'd0);
            next_cyc(); @(negedge clk);
            chk("err_valid", 64'(bus0.ifu_rsp_valid), 64'd1);
            chk("err_flag",  64'(bus0.ifu_rsp_err),   64'd1);
            chk("err_instr", 64'(bus0.ifu_rsp_instr), 64'd0);
            next_cyc();
        end
`endif

        // WAIT_CYC=3: cs at T+4, response at T+5, ready low T+1..T+4.
        bus3.ifu_req_valid = 1'b1;
        bus3.ifu_req_pc    = 32'h8000_000C;
        @(negedge clk);
        chk("w3_ready_t0", 64'(bus3.ifu_req_ready), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            next_cyc(); bus3.ifu_req_valid = 1'b0;
            @(negedge clk);
            chk("w3_ready_low", 64'(bus3.ifu_req_ready), 64'd0);
            chk("w3_cs",        64'(bus3.sram_cs),       64'(k == 4));
            chk("w3_valid_low", 64'(bus3.ifu_rsp_valid), 64'd0);
        end
        next_cyc(); @(negedge clk);
        chk("w3_valid", 64'(bus3.ifu_rsp_valid), 64'd1);
        chk("w3_instr", 64'(bus3.ifu_rsp_instr), 64'(mem[3]));
        next_cyc(); @(negedge clk);
        chk("w3_done", 64'(bus3.ifu_rsp_valid), 64'd0);

        // Random traffic on dut0, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            next_cyc();
            rst = ($urandom_range(0, 399) == 0);
            bus0.ifu_req_valid = !rst && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) bus0.ifu_req_pc = $urandom;
            else bus0.ifu_req_pc = BASE | (32'($urandom_range(0, (1 << AW) - 1)) << 2);
            bus0.ifu_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        next_cyc();
        rst = 1'b0;
        req0(1'b0, 32'h0, 1'b1);
        repeat (10) next_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
